serial_approx_adder: RTL and testbench
======================================

# serial_approx_adder

Bit-serial approximate adder that consumes the one-bit carry-lookahead cell, one bit position per clock, to add two WIDTH-bit operands. It is the stage directly downstream of the one-bit cell: it owns the carry register, operand shifting and start/done handshake. It sits between the approximate multiplier's partial-product generator and its accumulator. The low APPROX_BITS positions can be replaced by a lower-part-OR approximation to cut switching power.

## Interface
- WIDTH, 8, operand and sum width; must be 1 or greater.
- APPROX_BITS, 4, number of approximated LSB positions; 0 to WIDTH. Used only when the macro is defined.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset; one clock domain only.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; latched when start is accepted.
- b  in  WIDTH  operand B; latched when start is accepted.
- cin  in  1  carry-in to bit 0; latched when start is accepted.
- busy  out  1  high while bit positions are being processed.
- done  out  1  one-cycle pulse; sum and cout are valid in that cycle.
- sum  out  WIDTH  result; held stable until the next accepted start.
- cout  out  1  carry out of bit WIDTH-1; held with sum.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: when start=1, latch a, b and cin, clear the bit index, and go to RUN.
- RUN: on each cycle, feed bit[idx] of A, B and the carry register into the one-bit cell. Shift the SUM bit into the sum register from the MSB side, update carry from C1, and increment idx. When idx=WIDTH-1, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. If start=1 in DONE, the new operands are latched and the FSM goes directly to RUN (back-to-back operation).
- start during RUN is ignored; the operands and the operation in flight are not disturbed.
- cout equals the carry register after the last bit.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, idx=0. Asserting rst_n mid-operation aborts immediately, with no done pulse.
- idx width is clog2(WIDTH), minimum 1. idx does not wrap while in RUN.

## Timing
- Let E0 be the edge where start is accepted.
- busy=1 after edges E0 through E0+WIDTH-1.
- done=1 and busy=0 after edge E0+WIDTH. Latency is WIDTH cycles, throughput is one add per WIDTH cycles.
- sum and cout update only on the final bit edge. Partial results are never visible on the outputs.
- No combinational path from inputs to outputs.

## Configuration
- Macro APPROX_LSB_EN.
- Defined:
  - For idx < APPROX_BITS, sum bit = a[idx] | b[idx], and the cell's carry is not used.
  - The carry into bit APPROX_BITS is a[APPROX_BITS-1] & b[APPROX_BITS-1].
  - cin is ignored when APPROX_BITS > 0.
  - If APPROX_BITS = WIDTH, cout = a[WIDTH-1] & b[WIDTH-1].
  - Latency is unchanged.
- Undefined: every position uses the exact cell, and the result equals a+b+cin. APPROX_BITS is ignored.

## Structure
- Shared package approx_adder_pkg holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a clog2-style width constant function;
  - the default WIDTH and APPROX_BITS.
- One sub-module: a single instance of one_bit_LCA (ports A, B, C0, C1, SUM), reused every cycle.
- The FSM, shift registers, carry register and approximation muxing live in serial_approx_adder.

## Test plan
- Macro off, WIDTH=8: a=0xFF, b=0x01, cin=0 -> done 8 cycles after start, sum=0x00, cout=1. Check busy high for exactly 8 cycles.
- Macro on, APPROX_BITS=4: a=0x0F, b=0x01 -> sum=0x0F, cout=0. The exact result would be 0x10.
- Macro on: a=0x18, b=0x08 -> sum=0x28, cout=0 (carry generated at bit 3). Macro on: a=0xF0, b=0x10, cin=1 -> sum=0x00, cout=1 (cin ignored).
- Pulse start during RUN with different operands -> result is unchanged. Then assert start in the DONE cycle -> second result appears exactly 8 cycles later, with no IDLE gap.
- Assert rst_n low at cycle 3 of RUN -> all outputs 0 immediately, no done pulse. After release, a fresh start gives the correct result.
- Randomized: 1000 operand pairs checked against a golden model (exact, or lower-part-OR per macro).

Source files
------------

// File: rtl/approx_adder_pkg.sv
// rtl/approx_adder_pkg.sv - shared FSM encoding, index-width helper and defaults for serial_approx_adder
package approx_adder_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_APPROX_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to index n positions; never less than one so a 1-bit operand still has an index.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/one_bit_LCA.sv
// rtl/one_bit_LCA.sv - one-bit carry-lookahead cell (generate/propagate form)
module one_bit_LCA (
    input  logic A,
    input  logic B,
    input  logic C0,
    output logic C1,
    output logic SUM
);

    logic gen;
    logic prop;

    assign gen  = A & B;
    assign prop = A ^ B;
    assign SUM  = prop ^ C0;
    assign C1   = gen | (prop & C0);

endmodule

// File: rtl/serial_approx_adder.sv
// rtl/serial_approx_adder.sv - bit-serial adder, one position per clock; APPROX_LSB_EN selects lower-part-OR LSBs
module serial_approx_adder
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int APPROX_BITS = DEFAULT_APPROX_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            IW       = idx_width(WIDTH);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    if (WIDTH < 1 || APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_bad_cfg
        $error("serial_approx_adder: WIDTH must be >= 1 and APPROX_BITS within 0..WIDTH");
    end

    state_t            state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  sum_sh;
    logic              carry;
    logic [IW-1:0]     idx;

    logic              bit_a;
    logic              bit_b;
    logic              cell_sum;
    logic              cell_c1;
    logic              sum_bit;
    logic              carry_next;
    logic [WIDTH-1:0]  sum_next;

    // Single shared cell; it sees the current position and the running carry every cycle.
    one_bit_LCA u_cell (
        .A   (bit_a),
        .B   (bit_b),
        .C0  (carry),
        .C1  (cell_c1),
        .SUM (cell_sum)
    );

    // Select the current bit position, pick exact or approximate result, and form the next partial sum.
    always_comb begin
        bit_a      = a_reg[idx];
        bit_b      = b_reg[idx];
        sum_bit    = cell_sum;
        carry_next = cell_c1;
`ifdef APPROX_LSB_EN
        if (int'(idx) < APPROX_BITS) begin
            // Lower part: OR the operands; only the top approximated position seeds the exact upper carry.
            sum_bit    = bit_a | bit_b;
            carry_next = (int'(idx) == APPROX_BITS - 1) ? (bit_a & bit_b) : 1'b0;
        end
`endif
        sum_next             = sum_sh >> 1;
        sum_next[WIDTH-1]    = sum_bit;
    end

    // Handshake FSM with registered busy/done; outputs change only on the last bit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        carry  <= cin;
                        idx    <= '0;
                        sum_sh <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_sh <= sum_next;
                    carry  <= carry_next;
                    if (idx == IDX_LAST) begin
                        sum   <= sum_next;
                        cout  <= carry_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_approx_adder.sv
// tb/tb_serial_approx_adder.sv - self-checking bench for serial_approx_adder (follows APPROX_LSB_EN)
module tb_serial_approx_adder;

    localparam int W  = 8;
    localparam int AB = 4;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vcin;
        logic [7:0] esum;
        logic       ecout;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       cin_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int         checks;
    int         errors;
    logic [8:0] exp_q[$];
    logic       prev_done;
    vec_t       vecs[$];

    serial_approx_adder #(.WIDTH(W), .APPROX_BITS(AB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .cin   (cin_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
`ifdef APPROX_LSB_EN
        logic [8:0] hi;
        logic [3:0] lo;
        logic       cy;
        lo = x[3:0] | y[3:0];
        cy = x[3] & y[3];
        hi = {5'b0, x[7:4]} + {5'b0, y[7:4]} + {8'b0, cy} + {8'b0, c & 1'b0};
        return {hi[4:0], lo};
`else
        return {1'b0, x} + {1'b0, y} + {8'b0, c};
`endif
    endfunction

    // Drive start before the next edge, release it after acceptance and record the expected result.
    task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic [8:0] e);
        a_in   = ta;
        b_in   = tb;
        cin_in = tc;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(e);
    endtask

    // Sample 1 time unit after each edge until done; latency and busy samples must both equal exp_lat.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        int bcnt;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, bcnt, exp_lat);
    endtask

    // Scoreboard: every done pulse pops one expected result; done must never last two cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check("done_single_cycle", prev_done, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done required=no_done");
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("sum", sum, e[7:0]);
                    check("cout", cout, e[8]);
                end
            end
            prev_done = done;
        end
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        checks    = 0;
        errors    = 0;
        prev_done = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin_in    = 1'b0;

`ifdef APPROX_LSB_EN
        vecs.push_back('{8'h0F, 8'h01, 1'b0, 8'h0F, 1'b0});
        vecs.push_back('{8'h18, 8'h08, 1'b0, 8'h28, 1'b0});
        vecs.push_back('{8'hF0, 8'h10, 1'b1, 8'h00, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{8'h88, 8'h88, 1'b0, 8'h18, 1'b1});
`else
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 8'h01, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});
        vecs.push_back('{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0});
        vecs.push_back('{8'h12, 8'h34, 1'b1, 8'h47, 1'b0});
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors with hand-derived expectations.
        for (int i = 0; i < vecs.size(); i++) begin
            launch(vecs[i].va, vecs[i].vb, vecs[i].vcin, {vecs[i].ecout, vecs[i].esum});
            wait_done("vec", W);
        end

        // start pulsed mid-run must not disturb the operation in flight.
        repeat (2) @(posedge clk);
        #1;
        launch(8'h12, 8'h34, 1'b0, model(8'h12, 8'h34, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        a_in   = 8'hFF;
        b_in   = 8'hFF;
        cin_in = 1'b1;
        start  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore_start", W - 5);

        // Back-to-back: start asserted in the DONE cycle, no IDLE gap.
        launch(8'h55, 8'h0A, 1'b1, model(8'h55, 8'h0A, 1'b1));
        wait_done("back_to_back", W);
        launch(8'hC3, 8'h3D, 1'b0, model(8'hC3, 8'h3D, 1'b0));
        wait_done("back_to_back2", W);

        // Reset in the middle of RUN aborts with no done pulse.
        launch(8'hAB, 8'hCD, 1'b1, model(8'hAB, 8'hCD, 1'b1));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_busy_held", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        launch(8'h3C, 8'h4B, 1'b1, model(8'h3C, 8'h4B, 1'b1));
        wait_done("after_reset", W);

        // Random operands against the golden model, with random idle gaps.
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            launch(ra, rb, rc, model(ra, rb, rc));
            wait_done("rand", W);
        end

        @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
